// File: rtl/axis_qam_demod.sv
// axis_qam_demod: hard-decision BPSK/QPSK/16-QAM demodulator packing bits MSB-first onto AXI4-Stream
module axis_qam_demod #(
   parameter int DATA_W = 23,
   parameter int N_SYM  = 64,
   parameter int OUT_W  = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   output logic                  s_axis_tready,
   input  logic [2*DATA_W+1:0]   s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [OUT_W-1:0]      m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  en,
   input  logic [1:0]            mode,
   input  logic [DATA_W-2:0]     qam_thr,
   output logic                  err_len
);
   localparam int CW = $clog2(N_SYM);
   localparam int BW = $clog2(OUT_W + 1);

   logic [CW-1:0]            cnt;
   logic [BW-1:0]            nbits, nbits_n, bps;
   logic [OUT_W-1:0]         sh, sh_n, word;
   logic [1:0]               mode_r, md;
   logic [DATA_W-2:0]        thr_r;
   logic signed [DATA_W-1:0] re, im, thr;
   logic                     re_in, im_in, acc, last, load;
   logic [3:0]               dec;
   logic                     unused;

   assign unused = ^{s_axis_tdata[DATA_W], s_axis_tdata[2*DATA_W+1]};
   // Output register free (or draining this cycle) is what lets a new symbol in.
   assign s_axis_tready = en && !areset && (!m_axis_tvalid || m_axis_tready);

   // Per-symbol decision using the frame's mode/threshold (live values on symbol 0).
   always_comb begin
      acc     = s_axis_tvalid && s_axis_tready;
      re      = s_axis_tdata[DATA_W-1:0];
      im      = s_axis_tdata[2*DATA_W:DATA_W+1];
      md      = (cnt == '0) ? mode : mode_r;
      thr     = $signed({1'b0, (cnt == '0) ? qam_thr : thr_r});
      re_in   = (re > -thr) && (re < thr);
      im_in   = (im > -thr) && (im < thr);
      dec     = (md == 2'd2) ? {re[DATA_W-1], re_in, im[DATA_W-1], im_in}
              : (md == 2'd0) ? {3'b000, re[DATA_W-1]}
              : {2'b00, re[DATA_W-1], im[DATA_W-1]};
      bps     = (md == 2'd2) ? BW'(4) : (md == 2'd0) ? BW'(1) : BW'(2);
      sh_n    = (sh << bps) | OUT_W'(dec);
      nbits_n = nbits + bps;
      last    = cnt == CW'(N_SYM - 1);
      load    = acc && (last || nbits_n == BW'(OUT_W));
      word    = sh_n << (BW'(OUT_W) - nbits_n);
   end

   // Symbol counting, bit packing, output word register and length-error pulse.
   always_ff @(posedge aclk) begin
      if (areset) begin
         cnt           <= '0;
         nbits         <= '0;
         sh            <= '0;
         mode_r        <= '0;
         thr_r         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         err_len       <= 1'b0;
      end else begin
         err_len <= acc && (s_axis_tlast != last);
         if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
         if (acc) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (cnt == '0) begin
               mode_r <= mode;
               thr_r  <= qam_thr;
            end
            sh    <= load ? '0 : sh_n;
            nbits <= load ? '0 : nbits_n;
         end
         if (load) begin
            m_axis_tdata  <= word;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last;
         end
      end
   end
endmodule

// File: tb/tb_axis_qam_demod.sv
// tb_axis_qam_demod: self-checking bench with a behavioural decoder model for two frame lengths
module tb_axis_qam_demod;
   logic        aclk = 1'b0, areset = 1'b1;
   logic [47:0] s_tdata [2];
   logic [31:0] m_tdata [2];
   logic [1:0]  mode [2];
   logic [21:0] thr [2];
   logic [1:0]  s_tvalid, s_tlast, s_tready, m_tready, m_tvalid, m_tlast, en, err_len;

   int          checks = 0, failures = 0;
   int          cnt_m [2], nb [2], rd [2], wr [2], capn [2], errs [2], th_m [2];
   logic [1:0]  md_m [2];
   logic [31:0] aw [2];
   logic [32:0] expq [2][0:63];
   logic [32:0] cap [2][0:255];
   logic [32:0] held_v [2];
   bit          err_pend [2], held [2], prev_rst [2];
   bit          rnd = 0;

   always #5 aclk = ~aclk;

   axis_qam_demod #(.DATA_W(23), .N_SYM(64), .OUT_W(32)) dut0 (
      .aclk(aclk), .areset(areset), .s_axis_tready(s_tready[0]), .s_axis_tdata(s_tdata[0]),
      .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]), .m_axis_tready(m_tready[0]),
      .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
      .en(en[0]), .mode(mode[0]), .qam_thr(thr[0]), .err_len(err_len[0]));

   axis_qam_demod #(.DATA_W(23), .N_SYM(60), .OUT_W(32)) dut1 (
      .aclk(aclk), .areset(areset), .s_axis_tready(s_tready[1]), .s_axis_tdata(s_tdata[1]),
      .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]), .m_axis_tready(m_tready[1]),
      .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
      .en(en[1]), .mode(mode[1]), .qam_thr(thr[1]), .err_len(err_len[1]));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic put(input int u, input bit b);
      aw[u][31-nb[u]] = b;
      nb[u]++;
   endtask

   // Reference decoder: bits placed straight into their final left-aligned position.
   task automatic model_accept(input int u);
      int re, im, n;
      bit last;
      n  = (u == 1) ? 60 : 64;
      re = $signed(s_tdata[u][22:0]);
      im = $signed(s_tdata[u][46:24]);
      if (cnt_m[u] == 0) begin
         md_m[u] = mode[u];
         th_m[u] = int'(thr[u]);
      end
      last = cnt_m[u] == n - 1;
      err_pend[u] = s_tlast[u] != last;
      if (md_m[u] == 2'd0) put(u, re < 0);
      else if (md_m[u] == 2'd2) begin
         put(u, re < 0); put(u, (re < 0 ? -re : re) < th_m[u]);
         put(u, im < 0); put(u, (im < 0 ? -im : im) < th_m[u]);
      end else begin
         put(u, re < 0); put(u, im < 0);
      end
      if (nb[u] == 32 || last) begin
         expq[u][wr[u] % 64] = {last, aw[u]};
         wr[u]++;
         aw[u] = '0;
         nb[u] = 0;
      end
      cnt_m[u] = last ? 0 : cnt_m[u] + 1;
   endtask

   // Every cycle: reset values, ready rule, err_len, stall stability, output words vs model.
   always @(negedge aclk) begin
      for (int u = 0; u < 2; u++) begin
         if (prev_rst[u]) begin
            chk("rst_tvalid", m_tvalid[u], 0);
            chk("rst_tlast", m_tlast[u], 0);
            chk("rst_tdata", m_tdata[u], 0);
            chk("rst_err_len", err_len[u], 0);
         end
         prev_rst[u] = areset;
         if (areset) begin
            chk("rst_tready", s_tready[u], 0);
            cnt_m[u] = 0; nb[u] = 0; aw[u] = '0; rd[u] = wr[u];
            err_pend[u] = 0; held[u] = 0;
         end else begin
            chk("tready", s_tready[u], en[u] && (!m_tvalid[u] || m_tready[u]));
            chk("err_len", err_len[u], err_pend[u]);
            errs[u] += int'(err_len[u]);
            if (held[u]) chk("stall_hold", {m_tvalid[u], m_tlast[u], m_tdata[u]}, {1'b1, held_v[u]});
            held[u]   = m_tvalid[u] && !m_tready[u];
            held_v[u] = {m_tlast[u], m_tdata[u]};
            if (m_tvalid[u] && m_tready[u]) begin
               cap[u][capn[u] % 256] = {m_tlast[u], m_tdata[u]};
               capn[u]++;
               if (rd[u] == wr[u]) chk("spurious_word", m_tvalid[u], 0);
               else begin
                  chk("word", {m_tlast[u], m_tdata[u]}, expq[u][rd[u] % 64]);
                  rd[u]++;
               end
            end
            err_pend[u] = 0;
            if (s_tvalid[u] && s_tready[u]) model_accept(u);
         end
      end
   end

   task automatic send(input int u, input int re, input int im, input bit last);
      int  t = 0;
      bit  a = 0;
      s_tdata[u]  = {1'($urandom), im[22:0], 1'($urandom), re[22:0]};
      s_tvalid[u] = 1'b1;
      s_tlast[u]  = last;
      while (!a && t < 2000) begin
         if (rnd) begin
            m_tready[u] = 1'($urandom);
            en[u]       = ($urandom % 4) != 0;
         end
         @(negedge aclk);
         a = s_tready[u];
         @(posedge aclk);
         #1;
         t++;
      end
      if (!a) chk("send_timeout", a, 1);
      s_tvalid[u] = 1'b0;
      s_tlast[u]  = 1'b0;
   endtask

   task automatic drain(input int u);
      int t = 0;
      while ((rd[u] != wr[u] || m_tvalid[u]) && t < 2000) begin
         m_tready[u] = rnd ? 1'($urandom) : 1'b1;
         @(posedge aclk);
         #1;
         t++;
      end
      rnd = 0;
      m_tready[u] = 1'b1;
      en[u] = 1'b1;
      chk("drain_pending", wr[u] - rd[u], 0);
   endtask

   task automatic alt_frame(input int u, input int n, input int r0, input int i0,
                            input int r1, input int i1, input int errpos);
      for (int i = 0; i < n; i++)
         send(u, (i % 2) ? r1 : r0, (i % 2) ? i1 : i0, i == n - 1 || i == errpos);
   endtask

   task automatic chk_words(input string nm, input int u, input int base, input int n,
                            input logic [31:0] w, input logic [31:0] lw);
      chk({nm, "_count"}, capn[u] - base, n);
      for (int k = 0; k < n; k++)
         chk(nm, cap[u][base + k], {k == n - 1, (k == n - 1) ? lw : w});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base, e0;
      for (int u = 0; u < 2; u++) begin
         s_tdata[u] = '0; mode[u] = 2'd1; thr[u] = '0;
      end
      s_tvalid = '0; s_tlast = '0; m_tready = 2'b11; en = 2'b11;
      repeat (3) @(posedge aclk);
      #1 areset = 1'b0;

      // QPSK alternating
      base = capn[0]; e0 = errs[0];
      alt_frame(0, 64, 1000, 1000, -1000, -1000, -1);
      drain(0);
      chk_words("qpsk", 0, base, 4, 32'h33333333, 32'h33333333);
      chk("qpsk_err", errs[0] - e0, 0);

      // BPSK, mid-frame mode change ignored
      mode[0] = 2'd0; base = capn[0];
      for (int i = 0; i < 64; i++) begin
         if (i == 5) mode[0] = 2'd2;
         send(0, (i < 32) ? 5 : -5, 777, i == 63);
      end
      drain(0);
      chk("bpsk_count", capn[0] - base, 2);
      chk("bpsk_w0", cap[0][base], {1'b0, 32'h00000000});
      chk("bpsk_w1", cap[0][base + 1], {1'b1, 32'hFFFFFFFF});

      // 16-QAM with threshold 2000, then most-negative re
      mode[0] = 2'd2; thr[0] = 22'd2000; base = capn[0];
      alt_frame(0, 64, 3000, 500, -500, -3000, -1);
      drain(0);
      chk_words("qam16", 0, base, 8, 32'h1E1E1E1E, 32'h1E1E1E1E);
      base = capn[0];
      alt_frame(0, 1, -4194304, 3000, 0, 0, 0);
      alt_frame(0, 63, 3000, 3000, 3000, 3000, -1);
      drain(0);
      chk("qam16_minneg", cap[0][base], {1'b0, 32'h80000000});

      // N_SYM=60 QPSK: padded final word
      mode[1] = 2'd1; base = capn[1];
      alt_frame(1, 60, 1000, 1000, -1000, -1000, -1);
      drain(1);
      chk_words("n60", 1, base, 4, 32'h33333333, 32'h33333300);

      // Random backpressure and enable, three modes incl. reserved
      base = capn[0]; thr[0] = 22'd2000; rnd = 1;
      for (int f = 0; f < 3; f++) begin
         mode[0] = (f == 0) ? 2'd2 : (f == 1) ? 2'd3 : 2'd0;
         for (int i = 0; i < 64; i++) begin
            int r, q;
            r = int'($urandom_range(8000)) - 4000;
            q = int'($urandom_range(8000)) - 4000;
            if ($urandom % 6 == 0) r = ($urandom % 2) ? 2000 : -2000;
            if ($urandom % 6 == 0) q = ($urandom % 2) ? 1999 : -1999;
            send(0, r, q, i == 63);
         end
      end
      drain(0);
      chk("rand_count", capn[0] - base, 14);

      // tlast early on symbol 10: one err_len pulse, framing unchanged
      mode[0] = 2'd1; base = capn[0]; e0 = errs[0];
      alt_frame(0, 64, 1000, 1000, -1000, -1000, 10);
      drain(0);
      chk("err_pulses", errs[0] - e0, 1);
      chk_words("err_frame", 0, base, 4, 32'h33333333, 32'h33333333);

      // Reset mid-frame with a word stalled in the output register
      m_tready[0] = 1'b0;
      alt_frame(0, 16, 1000, 1000, -1000, -1000, -1);
      @(negedge aclk);
      chk("pre_rst_tvalid", m_tvalid[0], 1);
      @(posedge aclk); #1 areset = 1'b1;
      @(posedge aclk); #1 areset = 1'b0;
      chk("mid_rst_tvalid", m_tvalid[0], 0);
      chk("mid_rst_tdata", m_tdata[0], 0);
      m_tready[0] = 1'b1; base = capn[0];
      alt_frame(0, 64, -1000, 1000, -1000, 1000, -1);
      drain(0);
      chk_words("post_rst", 0, base, 4, 32'hAAAAAAAA, 32'hAAAAAAAA);

      repeat (3) @(posedge aclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
